if_id_stage_buf: RTL

Parametrised IF/ID pipeline stage buffer between fetch and decode. It carries the PC+1 value and the instruction word under a valid/ready handshake instead of a bare write-enable. In skid mode it has a two-entry buffer, so `in_ready` is a registered signal. Flush squashes every held entry to a NOP bubble, and reset is synchronous.

---
 rtl/if_id_stage_buf_pkg.sv | 29 ++
 rtl/if_id_stage_buf_pipe_skid_reg.sv | 125 ++++++++++++
 rtl/if_id_stage_buf.sv | 66 ++++++
 3 files changed

// File: rtl/if_id_stage_buf_pkg.sv
// ---------------------------------------------------------------------------
// if_id_stage_buf_pkg
// Shared pipeline definitions for the IF/ID stage buffer and later stage
// buffers built on the same skid register.
//   PC_W_DEF / INSTR_W_DEF : default PC+1 and instruction field widths
//   NOP_INSTR_DEF          : default bubble encoding (all-zero)
//   if_id_payload_t        : packed {pc_plus1, instr} at default widths
//   skid_state_t           : occupancy state of pipe_skid_reg; the encoding
//                            equals the number of held entries
// ---------------------------------------------------------------------------
package if_id_stage_buf_pkg;

    localparam int PC_W_DEF    = 8;
    localparam int INSTR_W_DEF = 32;

    localparam logic [INSTR_W_DEF-1:0] NOP_INSTR_DEF = '0;

    typedef struct packed {
        logic [PC_W_DEF-1:0]    pc_plus1;
        logic [INSTR_W_DEF-1:0] instr;
    } if_id_payload_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/if_id_stage_buf_pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
// Generic W-bit pipeline register with optional second (skid) entry and a
// flush input.
//   clk, rst        : clock, synchronous active-high reset
//   flush_i         : drop every held entry at the next edge
//   in_valid_i/in_ready_o/in_data_i    : upstream side
//   out_valid_o/out_ready_i/out_data_o : downstream side (head entry)
//   state_o         : current FSM state (EMPTY/ONE/TWO), also the occupancy
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready on the same side, and once
// out_valid_o is high the head word holds until it is taken or flushed.
//
// SKID=1: in_ready_o comes from a register (cuts the ready path from
// downstream). SKID=0: in_ready_o = !main_valid || out_ready_i.
// Reset and flush load CLEAR_VAL into both data registers.
// ---------------------------------------------------------------------------
module pipe_skid_reg
    import if_id_stage_buf_pkg::*;
#(
    parameter int         W         = 8,
    parameter bit         SKID      = 1'b1,
    parameter logic [W-1:0] CLEAR_VAL = '0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [W-1:0] out_data_o,
    output skid_state_t state_o
);

    skid_state_t  state_q, state_d;
    logic         ready_q, ready_d;
    logic [W-1:0] main_q, skid_q;
    logic         in_xfer, out_xfer;
    logic         main_ld_in, main_ld_skid, skid_ld;

    // State register (plus the registered ready that mirrors it).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
        end
    end

    // Next-state logic and datapath load strobes.
    always_comb begin
        state_d      = state_q;
        main_ld_in   = 1'b0;
        main_ld_skid = 1'b0;
        skid_ld      = 1'b0;
        in_xfer      = in_valid_i && in_ready_o;
        out_xfer     = out_valid_o && out_ready_i;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d    = ST_ONE;
                        main_ld_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_ld_in = 1'b1;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end else if (in_xfer && SKID) begin
                        // Head is stalled: park the new word behind it.
                        state_d = ST_TWO;
                        skid_ld = 1'b1;
                    end
                end
                ST_TWO: begin
                    if (out_xfer) begin
                        state_d      = ST_ONE;
                        main_ld_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        ready_d = (state_d != ST_TWO);
    end

    // Output logic.
    always_comb begin
        out_valid_o = (state_q != ST_EMPTY);
        out_data_o  = main_q;
        state_o     = state_q;
        if (SKID) begin
            in_ready_o = ready_q && !rst;
        end else begin
            in_ready_o = !rst && ((state_q == ST_EMPTY) || out_ready_i);
        end
    end

    // Payload registers.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            main_q <= CLEAR_VAL;
            skid_q <= CLEAR_VAL;
        end else begin
            if (main_ld_in) begin
                main_q <= in_data_i;
            end else if (main_ld_skid) begin
                main_q <= skid_q;
            end
            if (skid_ld) begin
                skid_q <= in_data_i;
            end
        end
    end

endmodule

// File: rtl/if_id_stage_buf.sv
// ---------------------------------------------------------------------------
// if_id_stage_buf
// IF/ID pipeline stage buffer carrying {PC+1, instruction} from fetch to
// decode under a valid/ready handshake, with flush-to-bubble.
//   clk, rst                          : clock, synchronous active-high reset
//   flush                             : squash all held entries
//   in_valid, in_ready, in_pc_plus1, in_instr     : fetch side
//   out_valid, out_ready, out_pc_plus1, out_instr : decode side
//   occupancy                         : held entries (0..2, 0..1 if SKID=0)
// out_instr shows NOP_INSTR whenever out_valid is low.
// ---------------------------------------------------------------------------
module if_id_stage_buf
    import if_id_stage_buf_pkg::*;
#(
    parameter int                 PC_W      = PC_W_DEF,
    parameter int                 INSTR_W   = INSTR_W_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF),
    parameter bit                 SKID      = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc_plus1,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc_plus1,
    output logic [INSTR_W-1:0] out_instr,
    output logic [1:0]         occupancy
);

    localparam int W = PC_W + INSTR_W;

    // Cleared entries hold PC 0 and the bubble instruction.
    localparam logic [W-1:0] CLEAR_VAL = {{PC_W{1'b0}}, NOP_INSTR};

    logic [W-1:0] in_data;
    logic [W-1:0] out_data;
    skid_state_t  state;

    assign in_data = {in_pc_plus1, in_instr};

    pipe_skid_reg #(
        .W         (W),
        .SKID      (SKID),
        .CLEAR_VAL (CLEAR_VAL)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .state_o     (state)
    );

    assign out_pc_plus1 = out_data[W-1 -: PC_W];
    assign out_instr    = out_valid ? out_data[INSTR_W-1:0] : NOP_INSTR;
    assign occupancy    = state;

endmodule
